// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ysyx_25020047_pkg;

  // Fetch controller states; IDLE is the reset state, FAULT is terminal.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } ifu_state_e;

  // fault_cause encodings.
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_ACCESS   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  // Architectural PC after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Instructions are 32-bit, so a fetchable PC has its low two bits clear.
  function automatic logic pc_aligned(input logic [31:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// 16-bit WAIT-cycle counter. expire flags that the current cycle is the
// TIMEOUT-th counted cycle, so the parent faults on the edge ending it.
module ifu_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the registered count only; the parent gates it with WAIT.
  assign expire = (cnt_q == LAST_CNT);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction-fetch controller: owns the PC, fetches over a
// valid/ready memory port, hands instructions to decode and waits for the
// writeback stage to commit the next PC. Faults are sticky until reset.
module ifu_fetch_ctrl
  import ysyx_25020047_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        wb_valid,
  input  logic [31:0] wb_dnpc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] retire_cnt
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retire_q, retire_d;
  logic [1:0]  fcause_q, fcause_d;
  logic [31:0] fpc_q, fpc_d;

  logic to_clr;
  logic to_en;
  logic to_expire;

  ifu_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (to_clr),
    .en     (to_en),
    .expire (to_expire)
  );

  // Next-state and datapath updates; everything defaults to hold.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    retire_d = retire_q;
    fcause_d = fcause_q;
    fpc_d    = fpc_q;
    to_clr   = 1'b0;
    to_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!pc_aligned(pc_q)) begin
          state_d  = S_FAULT;
          fcause_d = FC_MISALIGN;
          fpc_d    = pc_q;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
          to_clr  = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // A response arriving in the expiry cycle still counts.
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d  = S_FAULT;
            fcause_d = FC_ACCESS;
            fpc_d    = pc_q;
          end else begin
            state_d = S_VALID;
            inst_d  = imem_resp_data;
          end
        end else begin
          to_en = 1'b1;
          if (to_expire) begin
            state_d  = S_FAULT;
            fcause_d = FC_TIMEOUT;
            fpc_d    = pc_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_VALID: begin
        if (out_ready) begin
          state_d  = S_EXEC;
          retire_d = retire_q + 32'd1;
        end else begin
          state_d = S_VALID;
        end
      end
      S_EXEC: begin
        if (wb_valid) begin
          state_d = S_REQ;
          pc_d    = wb_dnpc;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= 32'd0;
      retire_q <= 32'd0;
      fcause_q <= FC_NONE;
      fpc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      retire_q <= retire_d;
      fcause_q <= fcause_d;
      fpc_q    <= fpc_d;
    end
  end

  // Outputs decoded from registered state only; a misaligned PC never requests.
  assign imem_req_valid = (state_q == S_REQ) && pc_aligned(pc_q);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_VALID);
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign fault          = (state_q == S_FAULT);
  assign fault_cause    = fcause_q;
  assign fault_pc       = fpc_q;
  assign retire_cnt     = retire_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl. The bench plays memory, decode and
// writeback; a transaction-level model tracks the expected PC, instruction
// word (a fixed function of the address) and retire count.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TO     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        imem_resp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_dnpc = 32'd0;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] retire_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_retire;

  ifu_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .wb_valid(wb_valid), .wb_dnpc(wb_dnpc),
    .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    imem_resp_err   = 1'b0;
    out_ready       = 1'b0;
    wb_valid        = 1'b0;
    wb_dnpc         = 32'd0;
  endtask

  // Reset, release, and advance into the first REQ cycle.
  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pc     = RST_PC;
    exp_retire = 32'd0;
    step();
  endtask

  // One full instruction from REQ back to REQ with the given stall lengths.
  task automatic run_fetch(input logic [31:0] dnpc, input int rs, input int rl,
                           input int ds, input int wl);
    logic [31:0] w;
    w = mem_word(exp_pc);
    for (int i = 0; i <= rs; i++) begin
      n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL req_valid: got %b want 1 (pc %h)", imem_req_valid, exp_pc); else n_pass++;
      n_checks++; if (imem_req_addr !== exp_pc) $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_pc); else n_pass++;
      imem_req_ready = (i == rs);
      step();
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i <= rl; i++) begin
      n_checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || fault !== 1'b0) $display("FAIL wait_outs: req %b out %b fault %b want 0 0 0", imem_req_valid, out_valid, fault); else n_pass++;
      imem_resp_valid = (i == rl);
      imem_resp_data  = (i == rl) ? w : $urandom;
      imem_resp_err   = 1'b0;
      wb_valid        = (i != rl);
      wb_dnpc         = $urandom;
      step();
    end
    quiet_inputs();
    for (int i = 0; i <= ds; i++) begin
      n_checks++; if (out_valid !== 1'b1) $display("FAIL out_valid: got %b want 1", out_valid); else n_pass++;
      n_checks++; if (out_inst !== w) $display("FAIL out_inst: got %h want %h", out_inst, w); else n_pass++;
      n_checks++; if (out_pc !== exp_pc) $display("FAIL out_pc: got %h want %h", out_pc, exp_pc); else n_pass++;
      n_checks++; if (retire_cnt !== exp_retire) $display("FAIL retire_valid: got %0d want %0d", retire_cnt, exp_retire); else n_pass++;
      out_ready       = (i == ds);
      imem_resp_valid = (i != ds);
      imem_resp_data  = $urandom;
      wb_valid        = (i != ds);
      wb_dnpc         = $urandom;
      step();
    end
    quiet_inputs();
    exp_retire = exp_retire + 32'd1;
    for (int i = 0; i <= wl; i++) begin
      n_checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0 || fault !== 1'b0) $display("FAIL exec_outs: out %b req %b fault %b want 0 0 0", out_valid, imem_req_valid, fault); else n_pass++;
      n_checks++; if (retire_cnt !== exp_retire) $display("FAIL retire_exec: got %0d want %0d", retire_cnt, exp_retire); else n_pass++;
      wb_valid        = (i == wl);
      wb_dnpc         = dnpc;
      imem_resp_valid = (i != wl);
      imem_resp_err   = 1'($urandom_range(1, 0));
      imem_resp_data  = $urandom;
      step();
    end
    quiet_inputs();
    exp_pc = dnpc;
    n_checks++; if (out_pc !== exp_pc) $display("FAIL out_pc_next: got %h want %h", out_pc, exp_pc); else n_pass++;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_valids: req %b out %b want 0 0", imem_req_valid, out_valid); else n_pass++;
    n_checks++; if (out_pc !== RST_PC || imem_req_addr !== RST_PC) $display("FAIL rst_pc: out_pc %h addr %h want %h", out_pc, imem_req_addr, RST_PC); else n_pass++;
    n_checks++; if (out_inst !== 32'd0 || retire_cnt !== 32'd0) $display("FAIL rst_data: inst %h retire %0d want 0 0", out_inst, retire_cnt); else n_pass++;
    n_checks++; if (fault !== 1'b0 || fault_cause !== 2'd0 || fault_pc !== 32'd0) $display("FAIL rst_fault: %b %0d %h want 0 0 0", fault, fault_cause, fault_pc); else n_pass++;
  endtask

  task automatic test_best_case();
    do_reset();
    for (int k = 1; k <= 3; k++) run_fetch(RST_PC + 32'(4 * k), 0, 0, 0, 0);
    n_checks++; if (retire_cnt !== 32'd3) $display("FAIL best_retire: got %0d want 3", retire_cnt); else n_pass++;
  endtask

  task automatic test_req_stall();
    run_fetch(exp_pc + 32'd4, 5, 3, 0, 0);
  endtask

  task automatic test_decode_stall();
    run_fetch(exp_pc + 32'd4, 0, 0, 4, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      run_fetch({$urandom_range(32'h3FFF_FFFF, 0) , 2'b00} , int'($urandom_range(4, 0)),
                int'($urandom_range(TO - 2, 0)), int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
    end
  endtask

  task automatic test_misaligned();
    run_fetch(32'h8000_0102, 0, 0, 0, 0);
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL mis_noreq: got %b want 0", imem_req_valid); else n_pass++;
    imem_req_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (fault !== 1'b1 || fault_cause !== 2'd1) $display("FAIL mis_fault: fault %b cause %0d want 1 1", fault, fault_cause); else n_pass++;
      n_checks++; if (fault_pc !== 32'h8000_0102) $display("FAIL mis_fpc: got %h want 80000102", fault_pc); else n_pass++;
      n_checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL mis_outs: req %b out %b want 0 0", imem_req_valid, out_valid); else n_pass++;
      imem_resp_valid = 1'b1;
      wb_valid        = 1'b1;
      out_ready       = 1'b1;
      step();
    end
    quiet_inputs();
  endtask

  task automatic test_access_err();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    quiet_inputs();
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    step();
    quiet_inputs();
    n_checks++; if (fault !== 1'b1 || fault_cause !== 2'd2) $display("FAIL acc_fault: fault %b cause %0d want 1 2", fault, fault_cause); else n_pass++;
    n_checks++; if (fault_pc !== RST_PC || out_valid !== 1'b0) $display("FAIL acc_fpc: fpc %h out %b want %h 0", fault_pc, out_valid, RST_PC); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    quiet_inputs();
    for (int k = 1; k <= TO; k++) begin
      n_checks++; if (fault !== 1'b0) $display("FAIL to_early: fault before WAIT cycle %0d ends", k); else n_pass++;
      step();
    end
    n_checks++; if (fault !== 1'b1 || fault_cause !== 2'd3) $display("FAIL to_fault: fault %b cause %0d want 1 3", fault, fault_cause); else n_pass++;
    n_checks++; if (fault_pc !== RST_PC) $display("FAIL to_fpc: got %h want %h", fault_pc, RST_PC); else n_pass++;
  endtask

  task automatic test_resp_wins();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    quiet_inputs();
    for (int k = 1; k < TO; k++) step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = mem_word(RST_PC);
    step();
    quiet_inputs();
    n_checks++; if (fault !== 1'b0 || out_valid !== 1'b1) $display("FAIL win_state: fault %b out %b want 0 1", fault, out_valid); else n_pass++;
    n_checks++; if (out_inst !== mem_word(RST_PC)) $display("FAIL win_inst: got %h want %h", out_inst, mem_word(RST_PC)); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    run_fetch(RST_PC + 32'h40, 0, 0, 0, 0);
    imem_req_ready = 1'b1;
    step();
    quiet_inputs();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_pc !== RST_PC || retire_cnt !== 32'd0 || out_inst !== 32'd0) $display("FAIL arst: pc %h retire %0d inst %h want %h 0 0", out_pc, retire_cnt, out_inst, RST_PC); else n_pass++;
    n_checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || fault !== 1'b0) $display("FAIL arst_outs: req %b out %b fault %b want 0 0 0", imem_req_valid, out_valid, fault); else n_pass++;
    step();
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) $display("FAIL stale_req: req %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RST_PC); else n_pass++;
      n_checks++; if (out_valid !== 1'b0 || out_inst !== 32'd0) $display("FAIL stale_out: out %b inst %h want 0 0", out_valid, out_inst); else n_pass++;
      step();
    end
    quiet_inputs();
    exp_pc     = RST_PC;
    exp_retire = 32'd0;
    run_fetch(RST_PC + 32'd4, 0, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_best_case();
    test_req_stall();
    test_decode_stall();
    test_random();
    test_misaligned();
    test_access_err();
    test_timeout();
    test_resp_wins();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
